// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel
// Description : N-channel PWM engine with a load-pulse slot sequencer and
//               frame-synchronous shadow registers, optional duty fading.
// Revision    : 1.0 - initial release
// ============================================================================

module pwm_multi_channel #(
    parameter int N_CH       = 3,
    parameter int WIDTH      = 8,
    parameter int PERIOD_RST = 63,
    parameter int OUT_INV    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_pulse,
    input  logic [WIDTH-1:0] din,
    input  logic             fade_en,
    output logic [N_CH:0]    slot_onehot,
    output logic [N_CH-1:0]  pwm_out,
    output logic             frame_tick,
    output logic             pending
);

    localparam logic [WIDTH-1:0] c_period_rst = WIDTH'(PERIOD_RST);
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);
    localparam logic             c_out_inv    = (OUT_INV != 0);

    logic [N_CH:0]      r_slot_onehot;
    logic [WIDTH-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_period_staged;
    logic [WIDTH-1:0]   r_period_active;
    logic               r_pending;

    logic [N_CH-1:0]    w_duty_diff;
    logic [N_CH-1:0]    w_pwm;
    logic               w_frame_tick;
    logic               w_any_diff;

    assign w_frame_tick = (r_cnt == r_period_active);
    assign w_any_diff   = (|w_duty_diff) || (r_period_staged != r_period_active);

    // Slot pointer is kept one-hot and rotated; bit0 addresses the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_onehot   <= {{N_CH{1'b0}}, 1'b1};
            r_cnt           <= '0;
            r_period_staged <= c_period_rst;
            r_period_active <= c_period_rst;
            r_pending       <= 1'b0;
        end else begin
            if (load_pulse) begin
                r_slot_onehot <= {r_slot_onehot[N_CH-1:0], r_slot_onehot[N_CH]};
            end
            if (load_pulse && r_slot_onehot[0]) begin
                r_period_staged <= din;
            end
            if (w_frame_tick) begin
                r_cnt           <= '0;
                r_period_active <= r_period_staged;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
            r_pending <= w_any_diff;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] r_staged;
        logic [WIDTH-1:0] r_active;
        logic [WIDTH-1:0] w_fade_next;
        logic             r_level;

        // One count toward the target; equal values hold, so no wrap is possible.
        always_comb begin
            w_fade_next = r_active;
            if (r_active < r_staged) begin
                w_fade_next = r_active + c_one;
            end else if (r_active > r_staged) begin
                w_fade_next = r_active - c_one;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_staged <= '0;
                r_active <= '0;
                r_level  <= c_out_inv;
            end else begin
                if (load_pulse && r_slot_onehot[i+1]) begin
                    r_staged <= din;
                end
                if (w_frame_tick) begin
                    r_active <= fade_en ? w_fade_next : r_staged;
                end
                r_level <= (r_cnt < r_active) ^ c_out_inv;
            end
        end

        assign w_duty_diff[i] = (r_staged != r_active);
        assign w_pwm[i]       = r_level;
    end

    assign slot_onehot = r_slot_onehot;
    assign pwm_out     = w_pwm;
    assign frame_tick  = w_frame_tick;
    assign pending     = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_channel
// Description : Self-checking bench for pwm_multi_channel (normal and
//               inverted-output instances against a frame-level model).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_pwm_multi_channel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_pulse;
    logic [7:0] din;
    logic       fade_en;

    logic [3:0] slot_onehot, slot_onehot_inv;
    logic [2:0] pwm_out, pwm_out_inv;
    logic       frame_tick, frame_tick_inv;
    logic       pending, pending_inv;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_multi_channel #(.N_CH(3), .WIDTH(8), .PERIOD_RST(63), .OUT_INV(0)) dut (
        .clk(clk), .rst_n(rst_n), .load_pulse(load_pulse), .din(din), .fade_en(fade_en),
        .slot_onehot(slot_onehot), .pwm_out(pwm_out), .frame_tick(frame_tick), .pending(pending)
    );

    pwm_multi_channel #(.N_CH(3), .WIDTH(8), .PERIOD_RST(63), .OUT_INV(1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .load_pulse(load_pulse), .din(din), .fade_en(fade_en),
        .slot_onehot(slot_onehot_inv), .pwm_out(pwm_out_inv), .frame_tick(frame_tick_inv),
        .pending(pending_inv)
    );

    // Reference model: index 0 = period, 1..3 = channel duties.
    int         m_stg[4];
    int         m_act[4];
    int         m_cnt;
    int         m_slot;
    logic [2:0] m_pwm;
    logic       m_pend;

    task automatic model_reset();
        m_stg  = '{63, 0, 0, 0};
        m_act  = '{63, 0, 0, 0};
        m_cnt  = 0;
        m_slot = 0;
        m_pwm  = 3'b000;
        m_pend = 1'b0;
    endtask

    task automatic model_step();
        bit tk;
        bit diff;
        tk   = (m_cnt == m_act[0]);
        diff = 0;
        for (int k = 0; k < 3; k++) m_pwm[k] = (m_cnt < m_act[k+1]);
        for (int k = 0; k < 4; k++) if (m_stg[k] != m_act[k]) diff = 1;
        m_pend = diff;
        if (tk) begin
            m_act[0] = m_stg[0];
            for (int k = 1; k < 4; k++) begin
                if (!fade_en)                m_act[k] = m_stg[k];
                else if (m_act[k] < m_stg[k]) m_act[k] = m_act[k] + 1;
                else if (m_act[k] > m_stg[k]) m_act[k] = m_act[k] - 1;
            end
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        if (load_pulse) begin
            m_stg[m_slot] = int'(din);
            m_slot        = (m_slot == 3) ? 0 : m_slot + 1;
        end
    endtask

    function automatic logic [17:0] obs();
        return {slot_onehot, slot_onehot_inv, pwm_out, pwm_out_inv,
                frame_tick, frame_tick_inv, pending, pending_inv};
    endfunction

    function automatic logic [17:0] expv();
        logic [3:0] oh;
        logic       tk;
        oh = 4'(1 << m_slot);
        tk = (m_cnt == m_act[0]);
        return {oh, oh, m_pwm, ~m_pwm, tk, tk, m_pend, m_pend};
    endfunction

    task automatic tick(input logic ld, input logic [7:0] d);
        @(negedge clk);
        load_pulse = ld;
        din        = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load4(input int p, input int d0, input int d1, input int d2);
        tick(1'b1, 8'(p));
        tick(1'b1, 8'(d0));
        tick(1'b1, 8'(d1));
        tick(1'b1, 8'(d2));
    endtask

    task automatic run_to_tick(output int n);
        n = 0;
        while (frame_tick !== 1'b1 && n < 200) begin
            tick(1'b0, 8'd0);
            n++;
        end
    endtask

    task automatic count_high(input int ch, input int len, output int hi);
        hi = 0;
        for (int k = 0; k < len; k++) begin
            tick(1'b0, 8'd0);
            if (pwm_out[ch] === 1'b1) hi++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; load_pulse = 1'b0; din = 8'd0; fade_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({slot_onehot, pwm_out, pwm_out_inv, frame_tick, pending} !== {4'b0001, 3'b000, 3'b111, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_initial: got %h expected %h",
                     {slot_onehot, pwm_out, pwm_out_inv, frame_tick, pending},
                     {4'b0001, 3'b000, 3'b111, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
        tick(1'b1, 8'd20);
        tick(1'b1, 8'd21);
        repeat (4) tick(1'b0, 8'd0);
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_partial_load: got %h expected %h", obs(), expv());
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({slot_onehot, slot_onehot_inv, pwm_out, pwm_out_inv, frame_tick, pending, pending_inv}
            !== {4'b0001, 4'b0001, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h",
                     {slot_onehot, slot_onehot_inv, pwm_out, pwm_out_inv, frame_tick, pending, pending_inv},
                     {4'b0001, 4'b0001, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        // cnt 0..63 after release: tick seen after 63 edges -> 64-clock frame
        run_to_tick(n);
        checks++;
        if (n !== 63) begin
            failures++;
            $display("FAIL first_frame_edges: got %0d expected 63", n);
        end
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL first_frame_state: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_load_sequence();
        logic [7:0] vals[4] = '{8'd9, 8'd3, 8'd0, 8'd10};
        logic [3:0] ohs[4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int         n;
        int         hi[3];
        int         ticks;
        tick(1'b0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, vals[i]);
            checks++;
            if (slot_onehot !== ohs[i]) begin
                failures++;
                $display("FAIL slot_walk[%0d]: got %b expected %b", i, slot_onehot, ohs[i]);
            end
        end
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL pending_after_load: got %b expected 1", pending);
        end
        run_to_tick(n);
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL load_seq_timeout: waited %0d cycles for frame_tick", n);
        end
        tick(1'b0, 8'd0);
        tick(1'b0, 8'd0);
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL pending_after_commit: got %b expected 0", pending);
        end
        hi = '{0, 0, 0};
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 8'd0);
            for (int c = 0; c < 3; c++) if (pwm_out[c] === 1'b1) hi[c]++;
            if (frame_tick === 1'b1) ticks++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL load_seq_model cyc=%0d: got %h expected %h", k, obs(), expv());
            end
        end
        checks++;
        if ({hi[0], hi[1], hi[2], ticks} !== {32'd3, 32'd0, 32'd10, 32'd1}) begin
            failures++;
            $display("FAIL duty_counts: got %0d/%0d/%0d ticks=%0d expected 3/0/10 ticks=1",
                     hi[0], hi[1], hi[2], ticks);
        end
    endtask

    task automatic test_midframe_update();
        int n;
        int hi;
        n = 0;
        while (m_cnt != 1 && n < 50) begin
            tick(1'b0, 8'd0);
            n++;
        end
        tick(1'b1, 8'd9);
        tick(1'b1, 8'd7);
        count_high(0, 7, hi);
        checks++;
        if (hi !== 0) begin
            failures++;
            $display("FAIL midframe_old_duty: got %0d highs expected 0", hi);
        end
        count_high(0, 10, hi);
        checks++;
        if (hi !== 7) begin
            failures++;
            $display("FAIL midframe_new_duty: got %0d highs expected 7", hi);
        end
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL midframe_model: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_load_on_tick();
        int n;
        int hi;
        tick(1'b1, 8'd0);
        tick(1'b1, 8'd10);
        tick(1'b1, 8'd9);
        tick(1'b1, 8'd7);
        run_to_tick(n);
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL on_tick_timeout: waited %0d cycles for frame_tick", n);
        end
        tick(1'b1, 8'd5);
        count_high(1, 10, hi);
        checks++;
        if (hi !== 0) begin
            failures++;
            $display("FAIL on_tick_deferred: got %0d highs expected 0", hi);
        end
        count_high(1, 10, hi);
        checks++;
        if (hi !== 5) begin
            failures++;
            $display("FAIL on_tick_applied: got %0d highs expected 5", hi);
        end
        tick(1'b1, 8'd10);
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL on_tick_model: got %h expected %h", obs(), expv());
        end
    endtask

    task automatic test_fade();
        int exp_up[6]   = '{1, 2, 3, 4, 5, 5};
        int exp_down[4] = '{4, 3, 2, 2};
        int n;
        int hi;
        fade_en = 1'b0;
        load4(9, 0, 0, 10);
        repeat (25) tick(1'b0, 8'd0);
        run_to_tick(n);
        tick(1'b0, 8'd0);
        fade_en = 1'b1;
        load4(9, 5, 0, 10);
        run_to_tick(n);
        tick(1'b0, 8'd0);
        for (int w = 0; w < 6; w++) begin
            count_high(0, 10, hi);
            checks++;
            if (hi !== exp_up[w]) begin
                failures++;
                $display("FAIL fade_up[%0d]: got %0d highs expected %0d", w, hi, exp_up[w]);
            end
        end
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL fade_pending_done: got %b expected 0", pending);
        end
        load4(9, 2, 0, 10);
        run_to_tick(n);
        tick(1'b0, 8'd0);
        for (int w = 0; w < 4; w++) begin
            count_high(0, 10, hi);
            checks++;
            if (hi !== exp_down[w]) begin
                failures++;
                $display("FAIL fade_down[%0d]: got %0d highs expected %0d", w, hi, exp_down[w]);
            end
        end
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL fade_model: got %h expected %h", obs(), expv());
        end
        fade_en = 1'b0;
    endtask

    task automatic test_period_zero();
        int n;
        load4(0, 3, 0, 10);
        run_to_tick(n);
        tick(1'b0, 8'd0);
        tick(1'b0, 8'd0);
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 8'd0);
            checks++;
            if ({frame_tick, frame_tick_inv, pwm_out, pwm_out_inv} !== {1'b1, 1'b1, 3'b101, 3'b010}) begin
                failures++;
                $display("FAIL period_zero cyc=%0d: got %b expected %b", k,
                         {frame_tick, frame_tick_inv, pwm_out, pwm_out_inv},
                         {1'b1, 1'b1, 3'b101, 3'b010});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if (c % 64 == 0) fade_en = 1'($urandom_range(0, 1));
            tick(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 12)));
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random_model cyc=%0d: got %h expected %h", c, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_sequence();
        test_midframe_update();
        test_load_on_tick();
        test_fade();
        test_period_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Parametrised N-channel PWM engine with an integrated load sequencer and frame-synchronous shadow registers. Each one-cycle load pulse writes data into the next register slot: slot 0 is the period, slots 1..N_CH are the channel duties. Staged values take effect only at a frame boundary, so outputs never glitch mid-frame. An optional fade mode steps each active duty one count per frame toward its staged target. Sits between the debounced load-pulse source and the LED output drivers.

Parameters:
N_CH, 3, number of PWM channels (1..8)
WIDTH, 8, width of period, duty and counter values
PERIOD_RST, 63, reset value of staged and active period
OUT_INV, 0, 1 = invert every pwm_out bit (active-low LEDs)

Ports:
clk  input  1  single clock domain, rising edge
rst_n  input  1  asynchronous active-low reset
load_pulse  input  1  one-cycle strobe; writes din into the current slot
din  input  WIDTH  load data
fade_en  input  1  1 = ramp active duties toward staged values; 0 = jump
slot_onehot  output  N_CH+1  one-hot current slot; bit0 = period
pwm_out  output  N_CH  registered PWM outputs
frame_tick  output  1  one-cycle pulse on the last count of each frame
pending  output  1  1 while any staged value differs from its active value

Behaviour:
- Reset (async, rst_n=0):
  - staged and active period = PERIOD_RST; all staged and active duties = 0.
  - cnt = 0; slot = 0, so slot_onehot = 1.
  - pwm_out = {N_CH{OUT_INV}}; frame_tick = 0; pending = 0.
  - A reset asserted mid-operation immediately forces all of the above. Partial loads are discarded.
- Load sequencer:
  - On load_pulse, staged[slot] <= din and slot advances 0 -> 1 -> ... -> N_CH -> 0 (wrap).
  - Without load_pulse, slot holds.
  - slot_onehot = 1 << slot, registered.
- Counter:
  - cnt runs 0..period_active inclusive, so a frame is period_active+1 clocks.
  - When cnt == period_active: cnt <= 0 and frame_tick = 1 for that same cycle (combinational from registered state).
  - period_active = 0: cnt stays 0 and frame_tick is constantly 1.
- Compare:
  - Raw level for channel i = (cnt < duty_active[i]).
  - pwm_out[i] is that level XOR OUT_INV, registered: it reflects the cnt value of the previous cycle (1-cycle latency).
  - duty = 0 gives always low. duty > period_active gives always high. duty == period_active gives high for period clocks, low for 1.
- Commit, on a frame_tick cycle only:
  - period_active <= period_staged.
  - fade_en = 0: duty_active[i] <= duty_staged[i].
  - fade_en = 1: duty_active[i] moves ±1 toward duty_staged[i], or holds if equal.
  - Between frame_ticks the active registers never change.
- Simultaneous load_pulse and frame_tick: the commit uses the pre-write staged value. The new value commits at the next frame_tick.
- pending: registered OR over all slots of (staged != active).
- Arithmetic: all compares are unsigned WIDTH-bit. The fade step saturates at the target; there is no wrap past 0 or 2^WIDTH-1.

Test Plan:
1. Assert rst_n=0 mid-frame (WIDTH=8, N_CH=3, OUT_INV=0) -> slot_onehot=4'b0001, pwm_out=3'b000, frame_tick=0, pending=0 immediately. The first frame after release is 64 clocks.
2. Pulses with din = 9, 3, 0, 10, fade_en=0 -> slot walks 0001 -> 0010 -> 0100 -> 1000 -> 0001. pending=1 until the next frame_tick. Afterwards: 10-clock frames, pwm_out[0] high 3 of 10, pwm_out[1] always 0, pwm_out[2] always 1.
3. Write a new ch0 duty (din=7) at cnt=2 -> pwm_out[0] keeps the old 3/10 waveform for the rest of the frame. It switches to 7/10 on the frame after the next frame_tick.
4. load_pulse on the frame_tick cycle itself -> the value does not take effect until the following frame_tick.
5. fade_en=1, active ch0 duty 0, staged 5 -> active duty goes 1, 2, 3, 4, 5 on successive frame_ticks, and pending drops the cycle after it reaches 5. Then stage 2 -> duty goes 4, 3, 2.
6. Load period 0 -> frame_tick constantly 1. Channels with duty ≥ 1 are constantly high, duty 0 constantly low. With OUT_INV=1 every level is inverted.
